// File: rtl/ddr3_app_pkg.sv
// Shared constants and helpers for the MIG-style application-side responder.
package ddr3_app_pkg;

    typedef enum logic [2:0] {
        CMD_WRITE = 3'b000,
        CMD_READ  = 3'b001
    } app_cmd_e;

    localparam int unsigned CMD_W      = 3;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned LFSR_W     = 16;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

    function automatic logic cmd_legal(input logic [CMD_W-1:0] c);
        return (c == CMD_WRITE) || (c == CMD_READ);
    endfunction

endpackage

// File: rtl/ddr3_app_resp_if.sv
// Application command / write-data / read-data bundle between driver and responder.
interface ddr3_app_resp_if #(
    parameter int unsigned ADDR_WIDTH = 28,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned MASK_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] app_addr;
    logic [2:0]            app_cmd;
    logic                  app_en;
    logic                  app_rdy;
    logic [DATA_WIDTH-1:0] app_wdf_data;
    logic [MASK_WIDTH-1:0] app_wdf_mask;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic                  app_wdf_rdy;
    logic [DATA_WIDTH-1:0] app_rd_data;
    logic                  app_rd_data_valid;
    logic                  app_rd_data_end;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );
endinterface

// File: rtl/ddr3_app_resp_fifo.sv
// Small synchronous FIFO with head-of-queue output; DEPTH must be a power of two.
module app_resp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_cnt;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_cnt == FULL_CNT);
    assign o_empty   = (r_cnt == '0);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_dout    = r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + (PTR_W+1)'(1);
                2'b01:   r_cnt <= r_cnt - (PTR_W+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/ddr3_app_resp.sv
// Stand-in for the memory controller: queues commands and write data, executes in order
// against an on-chip burst array and returns read data after a fixed latency.
module ddr3_app_resp
    import ddr3_app_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 28,
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned MASK_WIDTH  = 32,
    parameter int unsigned MEM_AW      = 8,
    parameter int unsigned RD_LATENCY  = 8,
    parameter int unsigned INIT_CYCLES = 64,
    parameter bit          BP_ENABLE   = 1'b1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
)(
    input  logic             ui_clk,
    input  logic             ui_rst,
    ddr3_app_resp_if.slave   app,
    output logic             init_calib_complete,
    output logic [15:0]      wr_count,
    output logic [15:0]      rd_count,
    output logic             proto_err
);
    localparam int unsigned CMD_EW = CMD_W + ADDR_WIDTH;
    localparam int unsigned WDF_EW = DATA_WIDTH + MASK_WIDTH;
    localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);

    typedef struct packed {
        logic [CMD_W-1:0]      cmd;
        logic [ADDR_WIDTH-1:0] addr;
    } cmd_entry_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [MASK_WIDTH-1:0] mask;
    } wdf_entry_t;

    logic [INIT_W-1:0]     r_init_cnt;
    logic                  r_init;
    logic [LFSR_W-1:0]     r_lfsr;
    logic [15:0]           r_wr_cnt;
    logic [15:0]           r_rd_cnt;
    logic                  r_proto;
    logic [RD_LATENCY-1:0] r_pv;
    logic [DATA_WIDTH-1:0] r_pd [RD_LATENCY];
    logic [DATA_WIDTH-1:0] r_mem [2**MEM_AW];

    logic                  w_bp_cmd, w_bp_wdf, w_app_rdy, w_wdf_rdy;
    logic                  w_cmd_push, w_cmd_pop, w_cmd_full, w_cmd_empty;
    logic                  w_wdf_push, w_wdf_pop, w_wdf_full, w_wdf_empty;
    cmd_entry_t            w_cmd_in, w_cmd_head;
    wdf_entry_t            w_wdf_in, w_wdf_head;
    logic                  w_head_wr, w_exec_rd, w_exec_wr;
    logic [MEM_AW-1:0]     w_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [RD_LATENCY:0]   w_pv_chain;
    logic [DATA_WIDTH-1:0] w_pd_chain [RD_LATENCY+1];
    logic                  w_proto_set;
    logic                  w_unused_addr;

    assign w_bp_cmd  = BP_ENABLE & (r_lfsr[3:0] == 4'd0);
    assign w_bp_wdf  = BP_ENABLE & (r_lfsr[7:4] == 4'd0);
    assign w_app_rdy = r_init & ~w_cmd_full & ~w_bp_cmd;
    assign w_wdf_rdy = r_init & ~w_wdf_full & ~w_bp_wdf;

    assign w_cmd_push = app.app_en & w_app_rdy;
    assign w_wdf_push = app.app_wdf_wren & w_wdf_rdy;
    assign w_cmd_in   = '{cmd: app.app_cmd, addr: app.app_addr};
    assign w_wdf_in   = '{data: app.app_wdf_data, mask: app.app_wdf_mask};

    app_resp_fifo #(.WIDTH(CMD_EW), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .i_clk(ui_clk), .i_rst(ui_rst), .i_push(w_cmd_push), .i_din(w_cmd_in),
        .i_pop(w_cmd_pop), .o_dout(w_cmd_head), .o_full(w_cmd_full), .o_empty(w_cmd_empty)
    );

    app_resp_fifo #(.WIDTH(WDF_EW), .DEPTH(FIFO_DEPTH)) u_wdf_fifo (
        .i_clk(ui_clk), .i_rst(ui_rst), .i_push(w_wdf_push), .i_din(w_wdf_in),
        .i_pop(w_wdf_pop), .o_dout(w_wdf_head), .o_full(w_wdf_full), .o_empty(w_wdf_empty)
    );

    // A write head waits for its data beat; reads and illegal commands always retire.
    assign w_head_wr = (w_cmd_head.cmd == CMD_WRITE);
    assign w_exec_rd = ~w_cmd_empty & (w_cmd_head.cmd == CMD_READ);
    assign w_exec_wr = ~w_cmd_empty & w_head_wr & ~w_wdf_empty;
    assign w_cmd_pop = ~w_cmd_empty & (~w_head_wr | ~w_wdf_empty);
    assign w_wdf_pop = w_exec_wr;

    assign w_idx         = w_cmd_head.addr[MEM_AW+2:3];
    assign w_rd_word     = r_mem[w_idx];
    assign w_unused_addr = ^{w_cmd_head.addr[ADDR_WIDTH-1:MEM_AW+3], w_cmd_head.addr[2:0]};

    assign w_pv_chain = {r_pv, w_exec_rd};
    always_comb begin
        w_pd_chain[0] = w_rd_word;
        for (int unsigned i = 0; i < RD_LATENCY; i++) w_pd_chain[i+1] = r_pd[i];
    end

    assign w_proto_set = (w_cmd_push & ~cmd_legal(app.app_cmd))
                       | (w_wdf_push & ~app.app_wdf_end)
                       | ((app.app_en | app.app_wdf_wren) & ~r_init);

    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            r_init_cnt <= '0;
            r_init     <= 1'b0;
            r_lfsr     <= LFSR_SEED;
            r_pv       <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) r_pd[i] <= '0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_proto    <= 1'b0;
        end else begin
            if (!r_init) begin
                r_init_cnt <= r_init_cnt + INIT_W'(1);
                if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) r_init <= 1'b1;
            end
            r_lfsr <= {r_lfsr[LFSR_W-2:0], lfsr_fb(r_lfsr)};
            r_pv   <= w_pv_chain[RD_LATENCY-1:0];
            // Data stages only load behind a valid so the output word holds between bursts.
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                if (w_pv_chain[i]) r_pd[i] <= w_pd_chain[i];
            end
            if (w_exec_wr)                  r_wr_cnt <= r_wr_cnt + 16'd1;
            if (w_pv_chain[RD_LATENCY-1])   r_rd_cnt <= r_rd_cnt + 16'd1;
            if (w_proto_set)                r_proto  <= 1'b1;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (w_exec_wr) begin
            for (int unsigned b = 0; b < MASK_WIDTH; b++) begin
                if (!w_wdf_head.mask[b]) r_mem[w_idx][b*8 +: 8] <= w_wdf_head.data[b*8 +: 8];
            end
        end
    end

    assign app.app_rdy           = w_app_rdy;
    assign app.app_wdf_rdy       = w_wdf_rdy;
    assign app.app_rd_data       = r_pd[RD_LATENCY-1];
    assign app.app_rd_data_valid = r_pv[RD_LATENCY-1];
    assign app.app_rd_data_end   = r_pv[RD_LATENCY-1];
    assign init_calib_complete   = r_init;
    assign wr_count              = r_wr_cnt;
    assign rd_count              = r_rd_cnt;
    assign proto_err             = r_proto;

endmodule
